// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- memory-access stage of the RISC-V softcore pipeline.
//
// Takes the exec->mem pipeline register and does byte/halfword/word loads and
// stores over a single-outstanding request/ack data bus. While a bus access
// is in flight it stalls the upstream pipeline. The result lands in the
// mem->wb register, which also acts as the mem->exec forwarding source.
//
// Ports
//   i_clk, i_rst_n           clock; asynchronous active-low reset
//   i_exec_mem_*             exec->mem pipeline register fields
//   o_dmem_req/we/addr/be/wdata, i_dmem_ack/rdata
//                            data-memory bus (word address, byte enables)
//   o_stall                  hold upstream stages and the exec->mem register
//   b_mem_wb_*               mem->wb pipeline register / forwarding source
//   o_misalign, o_bus_err    registered one-cycle fault pulses
//
// Parameter
//   ACK_TIMEOUT              REQ cycles allowed before abort (1..65535)
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_exec_mem_valid,
    input  logic [5:0]  i_exec_mem_rd,
    input  logic        i_exec_mem_writeback,
    input  logic        i_exec_mem_link,
    input  logic        i_exec_mem_mem_w,
    input  logic        i_exec_mem_mem_r,
    input  logic        i_exec_mem_mem_rdu,
    input  logic        i_exec_mem_mem_byte,
    input  logic        i_exec_mem_mem_hwrd,
    input  logic [31:0] i_exec_mem_alu_result,
    input  logic [31:0] i_exec_mem_mem_wdata,
    input  logic [31:0] i_exec_mem_pc,

    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,

    output logic        o_stall,

    output logic        b_mem_wb_valid,
    output logic        b_mem_wb_writeback,
    output logic [5:0]  b_mem_wb_rd,
    output logic [31:0] b_mem_wb_result,

    output logic        o_misalign,
    output logic        o_bus_err
);

    // Last counter value before abort; counter starts at 0 on REQ entry, so
    // abort happens on the ACK_TIMEOUT-th REQ cycle.
    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched request fields, held stable for the whole REQ phase.
    logic [31:0] r_dmem_addr;
    logic [3:0]  r_dmem_be;
    logic [31:0] r_dmem_wdata;
    logic        r_dmem_we;
    logic [31:0] r_ea;          // full effective address (lane + store result)
    logic        r_byte;
    logic        r_hwrd;
    logic        r_rdu;
    logic [5:0]  r_rd;
    logic        r_wb;
    logic [15:0] r_cnt;

    // -----------------------------------------------------------------------
    // Decode of the incoming instruction
    // -----------------------------------------------------------------------
    logic        w_memop;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_start;
    logic        w_in_idle;
    logic        w_in_req;
    logic        w_ack;
    logic        w_abort;
    logic [31:0] w_alu_value;

    assign w_memop      = i_exec_mem_valid & (i_exec_mem_mem_r | i_exec_mem_mem_w);
    assign w_is_word    = ~i_exec_mem_mem_byte & ~i_exec_mem_mem_hwrd;
    // Byte size wins if both size bits are set; bytes are never misaligned.
    assign w_misaligned = (~i_exec_mem_mem_byte & i_exec_mem_mem_hwrd & i_exec_mem_alu_result[0])
                        | (w_is_word & (i_exec_mem_alu_result[1:0] != 2'b00));
    assign w_in_idle    = (r_state == S_IDLE);
    assign w_in_req     = (r_state == S_REQ);
    assign w_start      = w_in_idle & w_memop & ~w_misaligned;
    // Ack outside REQ is ignored by qualifying it with the state.
    assign w_ack        = w_in_req & i_dmem_ack;
    assign w_abort      = w_in_req & ~i_dmem_ack & (r_cnt == CNT_LAST);
    assign w_alu_value  = i_exec_mem_link ? (i_exec_mem_pc + 32'd4) : i_exec_mem_alu_result;

    // -----------------------------------------------------------------------
    // Store lane placement
    // -----------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_exec_mem_mem_wdata;
        if (i_exec_mem_mem_w) begin
            if (i_exec_mem_mem_byte) begin
                w_be    = 4'b0001 << i_exec_mem_alu_result[1:0];
                w_wdata = {4{i_exec_mem_mem_wdata[7:0]}};
            end else if (i_exec_mem_mem_hwrd) begin
                w_be    = i_exec_mem_alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_exec_mem_mem_wdata[15:0]}};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Load lane selection and extension
    // -----------------------------------------------------------------------
    logic [7:0]  w_rd_byte_lane [4];
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load_value;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_rd_byte_lane[gi] = i_dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_rd_byte = w_rd_byte_lane[r_ea[1:0]];
    assign w_rd_half = r_ea[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

    always_comb begin
        w_load_value = i_dmem_rdata;
        if (r_byte) begin
            w_load_value = {{24{~r_rdu & w_rd_byte[7]}}, w_rd_byte};
        end else if (r_hwrd) begin
            w_load_value = {{16{~r_rdu & w_rd_half[15]}}, w_rd_half};
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack || w_abort) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Stall covers the entry cycle and every REQ cycle except the last one.
    assign o_stall = w_start | (w_in_req & ~i_dmem_ack & ~w_abort);

    // -----------------------------------------------------------------------
    // Request latch, timeout counter and mem->wb register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dmem_addr        <= '0;
            r_dmem_be          <= '0;
            r_dmem_wdata       <= '0;
            r_dmem_we          <= 1'b0;
            r_ea               <= '0;
            r_byte             <= 1'b0;
            r_hwrd             <= 1'b0;
            r_rdu              <= 1'b0;
            r_rd               <= '0;
            r_wb               <= 1'b0;
            r_cnt              <= '0;
            b_mem_wb_valid     <= 1'b0;
            b_mem_wb_writeback <= 1'b0;
            b_mem_wb_rd        <= '0;
            b_mem_wb_result    <= '0;
            o_misalign         <= 1'b0;
            o_bus_err          <= 1'b0;
        end else begin
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
            if (w_in_idle) begin
                if (w_start) begin
                    r_dmem_addr        <= {i_exec_mem_alu_result[31:2], 2'b00};
                    r_dmem_be          <= w_be;
                    r_dmem_wdata       <= w_wdata;
                    r_dmem_we          <= i_exec_mem_mem_w;
                    r_ea               <= i_exec_mem_alu_result;
                    r_byte             <= i_exec_mem_mem_byte;
                    r_hwrd             <= i_exec_mem_mem_hwrd;
                    r_rdu              <= i_exec_mem_mem_rdu;
                    r_rd               <= i_exec_mem_rd;
                    r_wb               <= i_exec_mem_writeback;
                    r_cnt              <= '0;
                    b_mem_wb_valid     <= 1'b0;
                    b_mem_wb_writeback <= 1'b0;
                end else begin
                    // Plain op, bubble, or misaligned memop (which retires
                    // without a bus access and without writing rd).
                    b_mem_wb_valid     <= i_exec_mem_valid;
                    b_mem_wb_rd        <= i_exec_mem_rd;
                    b_mem_wb_result    <= w_alu_value;
                    b_mem_wb_writeback <= i_exec_mem_valid & i_exec_mem_writeback
                                        & (|i_exec_mem_rd) & ~w_memop;
                    o_misalign         <= w_memop;
                end
            end else begin
                if (w_ack) begin
                    b_mem_wb_valid     <= 1'b1;
                    b_mem_wb_rd        <= r_rd;
                    b_mem_wb_result    <= r_dmem_we ? r_ea : w_load_value;
                    b_mem_wb_writeback <= ~r_dmem_we & r_wb & (|r_rd);
                end else if (w_abort) begin
                    b_mem_wb_valid     <= 1'b1;
                    b_mem_wb_rd        <= r_rd;
                    b_mem_wb_result    <= r_ea;
                    b_mem_wb_writeback <= 1'b0;
                    o_bus_err          <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign o_dmem_req   = w_in_req;
    assign o_dmem_we    = r_dmem_we;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_be    = r_dmem_be;
    assign o_dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_exec_mem_valid = 1'b0;
    logic [5:0]  i_exec_mem_rd = '0;
    logic        i_exec_mem_writeback = 1'b0;
    logic        i_exec_mem_link = 1'b0;
    logic        i_exec_mem_mem_w = 1'b0;
    logic        i_exec_mem_mem_r = 1'b0;
    logic        i_exec_mem_mem_rdu = 1'b0;
    logic        i_exec_mem_mem_byte = 1'b0;
    logic        i_exec_mem_mem_hwrd = 1'b0;
    logic [31:0] i_exec_mem_alu_result = '0;
    logic [31:0] i_exec_mem_mem_wdata = '0;
    logic [31:0] i_exec_mem_pc = '0;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_stall;
    logic        b_mem_wb_valid;
    logic        b_mem_wb_writeback;
    logic [5:0]  b_mem_wb_rd;
    logic [31:0] b_mem_wb_result;
    logic        o_misalign;
    logic        o_bus_err;

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_exec_mem_valid      (i_exec_mem_valid),
        .i_exec_mem_rd         (i_exec_mem_rd),
        .i_exec_mem_writeback  (i_exec_mem_writeback),
        .i_exec_mem_link       (i_exec_mem_link),
        .i_exec_mem_mem_w      (i_exec_mem_mem_w),
        .i_exec_mem_mem_r      (i_exec_mem_mem_r),
        .i_exec_mem_mem_rdu    (i_exec_mem_mem_rdu),
        .i_exec_mem_mem_byte   (i_exec_mem_mem_byte),
        .i_exec_mem_mem_hwrd   (i_exec_mem_mem_hwrd),
        .i_exec_mem_alu_result (i_exec_mem_alu_result),
        .i_exec_mem_mem_wdata  (i_exec_mem_mem_wdata),
        .i_exec_mem_pc         (i_exec_mem_pc),
        .o_dmem_req            (o_dmem_req),
        .o_dmem_we             (o_dmem_we),
        .o_dmem_addr           (o_dmem_addr),
        .o_dmem_be             (o_dmem_be),
        .o_dmem_wdata          (o_dmem_wdata),
        .i_dmem_ack            (i_dmem_ack),
        .i_dmem_rdata          (i_dmem_rdata),
        .o_stall               (o_stall),
        .b_mem_wb_valid        (b_mem_wb_valid),
        .b_mem_wb_writeback    (b_mem_wb_writeback),
        .b_mem_wb_rd           (b_mem_wb_rd),
        .b_mem_wb_result       (b_mem_wb_result),
        .o_misalign            (o_misalign),
        .o_bus_err             (o_bus_err)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct {
        logic [5:0]  rd;
        logic        wb;
        logic [31:0] res;
        bit          chk_res;
        logic        mis;
        logic        err;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_wd;
        int          cycles;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];

    int n_vec  = 0;
    int n_fail = 0;
    bit mon_en  = 1'b0;
    bit resp_en = 1'b0;
    int ack_delay = 0;   // REQ cycle (1-based) that gets the ack; 0 = never

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: acks on the chosen REQ cycle.
    initial begin
        int rq;
        rq = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (resp_en) begin
                if (o_dmem_req) begin
                    rq++;
                    i_dmem_ack = (ack_delay != 0) && (rq == ack_delay);
                end else begin
                    rq = 0;
                    i_dmem_ack = 1'b0;
                end
            end else begin
                rq = 0;
            end
        end
    end

    // mem->wb monitor
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge i_clk);
            if (mon_en && i_rst_n) begin
                if (b_mem_wb_valid) begin
                    if (wb_q.size() == 0) begin
                        chk("wb_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = wb_q.pop_front();
                        chk("wb_rd", 32'(b_mem_wb_rd), 32'(e.rd));
                        chk("wb_writeback", 32'(b_mem_wb_writeback), 32'(e.wb));
                        if (e.chk_res) chk("wb_result", b_mem_wb_result, e.res);
                        chk("misalign", 32'(o_misalign), 32'(e.mis));
                        chk("bus_err", 32'(o_bus_err), 32'(e.err));
                        $display("wb: rd=%0d wb=%0b result=%h mis=%0b err=%0b",
                                 b_mem_wb_rd, b_mem_wb_writeback, b_mem_wb_result, o_misalign, o_bus_err);
                    end
                end else begin
                    chk("pulse_idle", {30'd0, o_misalign, o_bus_err}, 32'd0);
                end
            end
        end
    end

    // bus monitor
    initial begin
        bus_exp_t cur;
        int  cyc;
        bit  prev;
        cur.cycles = -1;
        cyc = 0;
        prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (mon_en && i_rst_n) begin
                if (o_dmem_req) begin
                    if (!prev) begin
                        if (bus_q.size() == 0) begin
                            chk("bus_unexpected", 32'd1, 32'd0);
                            cur.cycles = -1;
                        end else begin
                            cur = bus_q.pop_front();
                            chk("bus_we", 32'(o_dmem_we), 32'(cur.we));
                            chk("bus_addr", o_dmem_addr, cur.addr);
                            chk("bus_be", 32'(o_dmem_be), 32'(cur.be));
                            if (cur.chk_wd) chk("bus_wdata", o_dmem_wdata, cur.wdata);
                            $display("bus: we=%0b addr=%h be=%b wdata=%h",
                                     o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata);
                        end
                        cyc = 1;
                    end else begin
                        cyc++;
                        if (cur.cycles >= 0) chk("bus_addr_held", o_dmem_addr, cur.addr);
                    end
                end else if (prev) begin
                    chk("req_cycles", 32'(cyc), 32'(cur.cycles));
                end
                prev = o_dmem_req;
            end else begin
                prev = 1'b0;
            end
        end
    end

    task automatic set_in(input logic v, input logic [5:0] rd, input logic wb, input logic link,
                          input logic mw, input logic mr, input logic rdu, input logic byt,
                          input logic hwrd, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] pc);
        i_exec_mem_valid      = v;
        i_exec_mem_rd         = rd;
        i_exec_mem_writeback  = wb;
        i_exec_mem_link       = link;
        i_exec_mem_mem_w      = mw;
        i_exec_mem_mem_r      = mr;
        i_exec_mem_mem_rdu    = rdu;
        i_exec_mem_mem_byte   = byt;
        i_exec_mem_mem_hwrd   = hwrd;
        i_exec_mem_alu_result = alu;
        i_exec_mem_mem_wdata  = wd;
        i_exec_mem_pc         = pc;
    endtask

    // Holds the current inputs until accepted, counting stall cycles.
    task automatic wait_accept(input int exp_stall);
        int n;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (!o_stall) break;
            n++;
            if (n > 50) begin
                chk("stall_timeout", 32'd1, 32'd0);
                break;
            end
        end
        chk("stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge i_clk);
        #2;
    endtask

    task automatic do_alu(input logic [5:0] rd, input logic wb, input logic link,
                          input logic [31:0] alu, input logic [31:0] pc,
                          input logic [31:0] exp_res, input logic exp_wb);
        wb_q.push_back('{rd: rd, wb: exp_wb, res: exp_res, chk_res: 1'b1, mis: 1'b0, err: 1'b0});
        set_in(1'b1, rd, wb, link, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alu, 32'h0, pc);
        wait_accept(0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [5:0] rd, input logic byt,
                           input logic hwrd, input logic rdu, input logic [31:0] rdata,
                           input int delay, input logic [31:0] exp_addr, input logic [31:0] exp_res);
        bus_q.push_back('{we: 1'b0, addr: exp_addr, be: 4'b1111, wdata: 32'h0, chk_wd: 1'b0, cycles: delay});
        wb_q.push_back('{rd: rd, wb: 1'b1, res: exp_res, chk_res: 1'b1, mis: 1'b0, err: 1'b0});
        ack_delay    = delay;
        i_dmem_rdata = rdata;
        set_in(1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b1, rdu, byt, hwrd, addr, 32'h0, 32'h0);
        wait_accept(delay);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic byt, input logic hwrd,
                            input logic [31:0] wd, input int delay, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        bus_q.push_back('{we: 1'b1, addr: exp_addr, be: exp_be, wdata: exp_wd, chk_wd: 1'b1, cycles: delay});
        wb_q.push_back('{rd: 6'd3, wb: 1'b0, res: addr, chk_res: 1'b1, mis: 1'b0, err: 1'b0});
        ack_delay = delay;
        set_in(1'b1, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, byt, hwrd, addr, wd, 32'h0);
        wait_accept(delay);
    endtask

    task automatic do_misalign(input logic [31:0] addr, input logic byt, input logic hwrd);
        wb_q.push_back('{rd: 6'd9, wb: 1'b0, res: 32'h0, chk_res: 1'b0, mis: 1'b1, err: 1'b0});
        set_in(1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, byt, hwrd, addr, 32'h0, 32'h0);
        wait_accept(0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_we", 32'(o_dmem_we), 32'd0);
        chk("rst_addr", o_dmem_addr, 32'h0);
        chk("rst_be", 32'(o_dmem_be), 32'h0);
        chk("rst_wdata", o_dmem_wdata, 32'h0);
        chk("rst_valid", 32'(b_mem_wb_valid), 32'd0);
        chk("rst_result", b_mem_wb_result, 32'h0);
        chk("rst_pulses", {30'd0, o_misalign, o_bus_err}, 32'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        mon_en  = 1'b1;
        resp_en = 1'b1;

        // ALU / link / rd=0
        do_alu(6'd5, 1'b1, 1'b0, 32'h0000_1234, 32'h0,         32'h0000_1234, 1'b1);
        do_alu(6'd1, 1'b1, 1'b1, 32'hDEAD_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        do_alu(6'd0, 1'b1, 1'b0, 32'h0000_0077, 32'h0,         32'h0000_0077, 1'b0);

        // Loads (back-to-back)
        do_load(32'h103, 6'd7,  1'b1, 1'b0, 1'b0, 32'h80AA_BBCC, 1, 32'h100, 32'hFFFF_FF80);
        do_load(32'h103, 6'd8,  1'b1, 1'b0, 1'b1, 32'h80AA_BBCC, 1, 32'h100, 32'h0000_0080);
        do_load(32'h102, 6'd10, 1'b0, 1'b1, 1'b0, 32'h80AA_BBCC, 1, 32'h100, 32'hFFFF_80AA);
        do_load(32'h100, 6'd11, 1'b0, 1'b1, 1'b1, 32'h1234_F00D, 2, 32'h100, 32'h0000_F00D);
        do_load(32'h101, 6'd12, 1'b1, 1'b0, 1'b0, 32'h1234_F00D, 1, 32'h100, 32'hFFFF_FFF0);
        do_load(32'h204, 6'd13, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 2, 32'h204, 32'h1234_5678);

        // Stores
        do_store(32'h102, 1'b1, 1'b0, 32'h0000_0055, 3, 32'h100, 4'b0100, 32'h5555_5555);
        do_store(32'h102, 1'b0, 1'b1, 32'h1234_ABCD, 2, 32'h100, 4'b1100, 32'hABCD_ABCD);
        do_store(32'h001, 1'b1, 1'b0, 32'h0000_00A5, 1, 32'h000, 4'b0010, 32'hA5A5_A5A5);
        do_store(32'h200, 1'b0, 1'b1, 32'h0000_BEEF, 1, 32'h200, 4'b0011, 32'hBEEF_BEEF);
        do_store(32'h200, 1'b0, 1'b0, 32'hDEAD_BEEF, 2, 32'h200, 4'b1111, 32'hDEAD_BEEF);

        // Misaligned
        do_misalign(32'h101, 1'b0, 1'b0);
        do_misalign(32'h103, 1'b0, 1'b1);
        do_alu(6'd6, 1'b1, 1'b0, 32'h0000_0042, 32'h0, 32'h0000_0042, 1'b1);

        // Timeout: never ack, ACK_TIMEOUT = 4
        bus_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'b1111, wdata: 32'h0, chk_wd: 1'b0, cycles: 4});
        wb_q.push_back('{rd: 6'd14, wb: 1'b0, res: 32'h0, chk_res: 1'b0, mis: 1'b0, err: 1'b1});
        ack_delay = 0;
        set_in(1'b1, 6'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
        wait_accept(4);
        do_alu(6'd15, 1'b1, 1'b0, 32'h0000_0099, 32'h0, 32'h0000_0099, 1'b1);
        set_in(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (6) @(posedge i_clk);
        #2;
        chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);

        // Reset in the middle of REQ
        mon_en  = 1'b0;
        resp_en = 1'b0;
        i_dmem_ack = 1'b0;
        set_in(1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0);
        @(posedge i_clk);
        #2;
        set_in(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge i_clk);
        chk("mid_req_active", 32'(o_dmem_req), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(o_dmem_req), 32'd0);
        chk("mid_rst_addr", o_dmem_addr, 32'h0);
        chk("mid_rst_be", 32'(o_dmem_be), 32'h0);
        chk("mid_rst_stall", 32'(o_stall), 32'd0);
        chk("mid_rst_valid", 32'(b_mem_wb_valid), 32'd0);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        chk("late_ack_stall", 32'(o_stall), 32'd0);
        @(posedge i_clk);
        #2;
        i_dmem_ack = 1'b0;
        @(negedge i_clk);
        chk("late_ack_req", 32'(o_dmem_req), 32'd0);
        chk("late_ack_valid", 32'(b_mem_wb_valid), 32'd0);
        chk("late_ack_pulses", {30'd0, o_misalign, o_bus_err}, 32'd0);
        @(posedge i_clk);
        #2;
        mon_en  = 1'b1;
        resp_en = 1'b1;
        do_alu(6'd2, 1'b1, 1'b0, 32'h0000_ABCD, 32'h0, 32'h0000_ABCD, 1'b1);
        do_load(32'h104, 6'd16, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 1, 32'h104, 32'hCAFE_F00D);
        set_in(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (4) @(posedge i_clk);
        #2;
        chk("final_wb_q_empty", 32'(wb_q.size()), 32'd0);
        chk("final_bus_q_empty", 32'(bus_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage of the RISC-V softcore: sits directly downstream of `execute` and upstream of writeback. Consumes the exec→mem pipeline register, performs byte, halfword and word loads and stores over a single-outstanding request/ack data-memory bus, and extends load data. Stalls the upstream pipeline while a bus access is in flight, then registers the mem→wb result. That result also serves as the mem→exec forwarding source.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles spent in REQ waiting for `i_dmem_ack` before the access is aborted; must be ≥1, max 65535.
- `i_clk` in 1: clock, all state updates on rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_exec_mem_valid` in 1: exec→mem register holds a real instruction (0 = bubble).
- `i_exec_mem_rd` in 6: destination register number.
- `i_exec_mem_writeback`, `i_exec_mem_link` in 1 each: rd write enable; result is pc+4.
- `i_exec_mem_mem_w`, `i_exec_mem_mem_r` in 1 each: store; load.
- `i_exec_mem_mem_rdu`, `i_exec_mem_mem_byte`, `i_exec_mem_mem_hwrd` in 1 each: unsigned load; byte size; halfword size. Neither size bit set means word.
- `i_exec_mem_alu_result` in 32: effective address for memory ops, result otherwise.
- `i_exec_mem_mem_wdata` in 32: store data (rs2), low bits significant.
- `i_exec_mem_pc` in 32: instruction PC.
- `o_dmem_req` out 1: bus request.
- `o_dmem_we` out 1: request is a write.
- `o_dmem_addr` out 32: word address, `[1:0]` = 0.
- `o_dmem_be` out 4: byte enables.
- `o_dmem_wdata` out 32: lane-replicated store data.
- `i_dmem_ack` in 1: request completes this cycle; read data valid.
- `i_dmem_rdata` in 32: read word.
- `o_stall` out 1: hold fetch/decode/execute and the exec→mem register this cycle.
- `b_mem_wb_valid`, `b_mem_wb_writeback` out 1 each: mem→wb register.
- `b_mem_wb_rd` out 6: mem→wb register; also the mem→exec forwarding register number.
- `b_mem_wb_result` out 32: mem→wb register; also the `mem_exec_forward` value.
- `o_misalign`, `o_bus_err` out 1 each: registered one-cycle fault pulses.

## Operation
- FSM states: IDLE and REQ.
- memop = `i_exec_mem_valid` & (`mem_r` | `mem_w`).
- Misaligned: hwrd with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, no memop or bubble: on the next edge load mem→wb.
  - valid ← input valid.
  - rd ← `i_exec_mem_rd`.
  - result ← link ? pc+4 (mod 2^32) : alu_result.
  - writeback ← valid & writeback & (rd≠0).
- IDLE, misaligned memop: no bus request, no stall. Load mem→wb with valid=1 and writeback=0; `o_misalign`=1 next cycle.
- IDLE, aligned memop: latch address, be, wdata, we, size, rdu, rd and writeback. Go to REQ, clear the timeout counter; mem→wb valid ← 0 (bubble).
- REQ: drive `o_dmem_req`=1 and the latched fields; they are held stable until ack or abort. Counter increments each cycle without ack.
- REQ with `i_dmem_ack`: go to IDLE, load mem→wb (valid=1).
  - Load: result ← extended data; writeback ← latched writeback & rd≠0.
  - Store: result ← address; writeback ← 0.
- REQ with counter = `ACK_TIMEOUT`-1 and no ack: abort to IDLE. mem→wb valid=1, writeback=0; `o_bus_err`=1 next cycle.
- Store lanes:
  - byte: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - hwrd: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - word: be = 4'b1111. Loads drive be = 4'b1111.
- Load extension: byte lane addr[1:0], halfword lane addr[1]. Zero-extend if rdu, else sign-extend. Word: unchanged.
- `i_dmem_ack` outside REQ is ignored.

## Timing
- Reset (async, immediate): state IDLE, counter 0, every b_ output 0, `o_dmem_req`/`o_misalign`/`o_bus_err` 0. Bus address, be, we and wdata are 0.
- Reset mid-REQ drops the request the same instant; a later ack is ignored.
- `o_stall` (combinational) = (IDLE & aligned memop) | (REQ & ~ack & ~abort).
- Non-memory ops: 1 cycle, never stall.
- Aligned memop: the request goes out the cycle after entry. Minimum 2 cycles, stall 1 cycle, when ack arrives in the first REQ cycle.
- Ack after k REQ cycles: stall k cycles; mem→wb updates at the end of the ack cycle.
- The upstream register advances at the end of the ack cycle; the next instruction is seen in IDLE the following cycle.
- Back-to-back memops: the second enters REQ one cycle after the first completes.
- Abort occurs after exactly `ACK_TIMEOUT` REQ cycles.

## Test plan
- Reset mid-REQ: load in flight, pull `i_rst_n` low → `o_dmem_req` drops immediately, all outputs 0. An ack after release is ignored; state stays IDLE.
- ALU op: rd=5, alu_result=0x1234, no mem → next cycle `b_mem_wb_result`=0x1234, writeback=1, `o_stall` never high.
  - Same with link=1, pc=0xFFFFFFFC → result 0x00000000.
  - rd=0 → writeback=0.
- LB: addr 0x103, rdata 0x80AABBCC, ack in first REQ cycle → `o_dmem_addr`=0x100, stall exactly 1 cycle, result 0xFFFFFF80.
  - Same with rdu=1 → 0x00000080.
  - LH addr 0x102 → 0xFFFF80AA.
- SB: wdata 0x55 to 0x102, ack after 3 REQ cycles → be=0100, wdata=0x55555555, req held 3 cycles, stall 3 cycles, writeback=0.
  - SH to 0x102 → be=1100.
- Misaligned: LW addr 0x101 → no `o_dmem_req`, no stall, `o_misalign` pulses 1 cycle, writeback=0.
  - LH addr 0x103 → same response.
- Timeout: `ACK_TIMEOUT`=4, never ack → req high exactly 4 cycles, then `o_bus_err` 1-cycle pulse, writeback=0, pipeline resumes.
